alpharetz_spi_ctrl_mm: RTL

Parametrised multi-mode SPI controller (master) for the Alpharetz IO subsystem. It generalises the single-mode controller with per-transaction SPI mode (CPOL/CPHA), a runtime clock divider, configurable word width and peripheral count, full-duplex receive capture, and an address-error report. It sits between the system-side register/bus logic and the off-chip SPI pins, with one active-low select per peripheral.

---
 rtl/alpharetz_spi_ctrl_mm.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alpharetz_spi_ctrl_mm.sv
// Multi-mode SPI master: per-transaction CPOL/CPHA, runtime divider, full-duplex
// capture, one active-low select per peripheral and an address-error pulse.
module alpharetz_spi_ctrl_mm #(
  parameter int DATA_WIDTH   = 8,
  parameter int PERI_CNT     = 4,
  parameter int P_ADDR_WIDTH = 2,
  parameter int DIV_WIDTH    = 8
) (
  input  logic                    sys_clk,
  input  logic                    sync_rst,
  input  logic                    sys_clk_en,
  input  logic                    start_txn,
  input  logic                    cpol,
  input  logic                    cpha,
  input  logic [DIV_WIDTH-1:0]    clk_div,
  input  logic [DATA_WIDTH-1:0]   tx_data,
  input  logic [P_ADDR_WIDTH-1:0] p_addr,
  input  logic                    cipo,
  output logic                    copi,
  output logic                    p_clk,
  output logic [PERI_CNT-1:0]     p_sel_n,
  output logic                    busy,
  output logic                    end_txn,
  output logic [DATA_WIDTH-1:0]   rx_data,
  output logic                    addr_err
);

  localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_TRAIL = 2'd3
  } state_t;

  state_t                  state_r;
  logic                    cpol_r;
  logic                    cpha_r;
  logic [DIV_WIDTH-1:0]    div_r;
  logic [DIV_WIDTH-1:0]    div_cnt_r;
  logic [EDGE_W-1:0]       edge_cnt_r;
  logic [DATA_WIDTH-1:0]   tx_sh_r;
  logic [DATA_WIDTH-1:0]   rx_sh_r;

  logic tick_s;
  logic addr_ok_s;
  logic lead_s;
  logic sample_s;
  logic last_s;
  logic drive_s;

  // Active-low one-hot decode of a peripheral index.
  function automatic logic [PERI_CNT-1:0] sel_decode(input logic [P_ADDR_WIDTH-1:0] a);
    logic [PERI_CNT-1:0] sel;
    for (int i = 0; i < PERI_CNT; i++) begin
      sel[i] = (P_ADDR_WIDTH'(i) == a) ? 1'b0 : 1'b1;
    end
    return sel;
  endfunction

  // Half-period expiry, address validity and the role of the next SCLK edge.
  assign tick_s    = (div_cnt_r == div_r);
  assign addr_ok_s = (32'(p_addr) < 32'(PERI_CNT));
  assign lead_s    = ~edge_cnt_r[0];
  assign sample_s  = lead_s ^ cpha_r;
  assign last_s    = (edge_cnt_r == (LAST_EDGE - EDGE_W'(1)));
  assign drive_s   = ~sample_s & ~last_s;

  // Transaction sequencer, divider, shift registers and all registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sync_rst) begin
      state_r    <= ST_IDLE;
      cpol_r     <= 1'b0;
      cpha_r     <= 1'b0;
      div_r      <= '0;
      div_cnt_r  <= '0;
      edge_cnt_r <= '0;
      tx_sh_r    <= '0;
      rx_sh_r    <= '0;
      copi       <= 1'b0;
      p_clk      <= 1'b0;
      p_sel_n    <= '1;
      busy       <= 1'b0;
      end_txn    <= 1'b0;
      rx_data    <= '0;
      addr_err   <= 1'b0;
    end else begin
      // Pulses last exactly one cycle even while the enable is low.
      end_txn  <= 1'b0;
      addr_err <= 1'b0;
      if (sys_clk_en) begin
        case (state_r)
          ST_IDLE: begin
            if (start_txn) begin
              if (addr_ok_s) begin
                state_r    <= ST_LEAD;
                cpol_r     <= cpol;
                cpha_r     <= cpha;
                div_r      <= clk_div;
                div_cnt_r  <= '0;
                edge_cnt_r <= '0;
                rx_sh_r    <= '0;
                p_clk      <= cpol;
                p_sel_n    <= sel_decode(p_addr);
                busy       <= 1'b1;
                if (!cpha) begin
                  // CPHA=0 presents the MSB before the first edge.
                  copi    <= tx_data[DATA_WIDTH-1];
                  tx_sh_r <= {tx_data[DATA_WIDTH-2:0], 1'b0};
                end else begin
                  tx_sh_r <= tx_data;
                end
              end else begin
                addr_err <= 1'b1;
              end
            end
          end
          ST_LEAD, ST_SHIFT: begin
            if (tick_s) begin
              div_cnt_r  <= '0;
              edge_cnt_r <= edge_cnt_r + EDGE_W'(1);
              p_clk      <= ~p_clk;
              if (sample_s) begin
                rx_sh_r <= {rx_sh_r[DATA_WIDTH-2:0], cipo};
              end
              if (drive_s) begin
                copi    <= tx_sh_r[DATA_WIDTH-1];
                tx_sh_r <= {tx_sh_r[DATA_WIDTH-2:0], 1'b0};
              end
              state_r <= last_s ? ST_TRAIL : ST_SHIFT;
            end else begin
              div_cnt_r <= div_cnt_r + DIV_WIDTH'(1);
            end
          end
          ST_TRAIL: begin
            if (tick_s) begin
              state_r   <= ST_IDLE;
              div_cnt_r <= '0;
              p_clk     <= cpol_r;
              p_sel_n   <= '1;
              busy      <= 1'b0;
              end_txn   <= 1'b1;
              rx_data   <= rx_sh_r;
            end else begin
              div_cnt_r <= div_cnt_r + DIV_WIDTH'(1);
            end
          end
          default: begin
            state_r <= ST_IDLE;
            p_sel_n <= '1;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
